seg_value_encoder: RTL
======================

# seg_value_encoder

Converts an 8-bit data-bus value into four 7-segment patterns, which feed directly into the four digit inputs of the multiplexed display driver. Conversion is a sequential shift-add-3 (double-dabble) binary-to-BCD pass, followed by segment encoding. Sign and leading-zero handling are included. Results are registered and held stable between conversions, so the display never shows partial values.

## Interface
- `SEG_ACTIVE_LOW`, default 1: 1 = segment on when bit is 0 (common-anode); 0 = segment on when bit is 1.
- `LZB`, default 1: 1 = blank leading zeros in hundreds/tens; 0 = always show three digits.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request conversion of `value`; sampled only in IDLE.
- `sgn`  in  1  1 = treat `value` as two's complement; sampled with `start`.
- `value`  in  8  number to display; sampled with `start`.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse; `b1..b4` updated this cycle.
- `b1`  out  7  leftmost digit pattern (sign position).
- `b2`  out  7  hundreds digit pattern.
- `b3`  out  7  tens digit pattern.
- `b4`  out  7  units digit pattern.

Pattern bit order, MSB to LSB: {a,b,c,d,e,f,g}. Bit 6 is segment a; bit 0 is segment g.

## Operation
- FSM states:
  - IDLE: `start`=1 → CONV.
  - CONV: 8 cycles → ENC.
  - ENC: 1 cycle → IDLE.
- On `start` in IDLE:
  - mag = (`sgn` & `value[7]`) ? −`value` : `value`.
  - Magnitude is unsigned 8-bit; −128 gives 128, no overflow.
  - neg = `sgn` & `value[7]`.
  - BCD accumulator is 12 bits and is cleared.
  - Iteration counter is cleared.
- CONV, each cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then {bcd, mag} is shifted left one bit.
  - Counter increments; leave CONV after the 8th shift.
- ENC:
  - `b4` = units glyph; never blanked.
  - `b3` = tens glyph, or blank if `LZB` & hundreds==0 & tens==0.
  - `b2` = hundreds glyph, or blank if `LZB` & hundreds==0.
  - `b1` = minus if neg, else blank.
  - `done` asserts.
- Active-low glyphs:
  - 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C
  - 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h04
  - minus=7'h7E, blank=7'h7F
- With `SEG_ACTIVE_LOW`=0, every pattern is the bitwise inverse.
- Unsigned range 0..255; signed range −128..127. Minus sign sits only in `b1`.
- `start` while `busy` is ignored; no queuing. The in-flight conversion completes unaffected.
- `value`/`sgn` changes after the start cycle have no effect.

## Timing
- Reset (async, immediate):
  - state=IDLE, `busy`=0, `done`=0.
  - `b1..b4` = blank pattern for the selected polarity.
  - Reset mid-conversion aborts with outputs blanked; no `done`.
- `start` sampled at edge k:
  - `busy`=1 after edge k.
  - CONV shifts occur on edges k+1..k+8.
  - Edge k+9 loads `b1..b4`, sets `done`=1, and clears `busy`.
  - Edge k+10 clears `done`.
- Latency is 9 clocks from the start edge to valid outputs.
- `start` high at edge k+10 (first IDLE cycle) is accepted, so back-to-back throughput is one conversion per 10 clocks.
- `start` at edge k+9 (ENC) is ignored.
- `b1..b4` change only at the ENC edge or on reset, and are glitch-free registered outputs.

## Test plan
- Reset, then `value`=0, `sgn`=0, `start` pulse:
  - `done` at 9 clocks.
  - `b1`=`b2`=`b3`=7'h7F, `b4`=7'h01.
  - `busy` high for exactly 9 cycles.
- `value`=255, `sgn`=0:
  - `b1`=7'h7F, `b2`=7'h12, `b3`=7'h24, `b4`=7'h24.
- `value`=8'h80, `sgn`=1:
  - `b1`=7'h7E, `b2`=7'h4F, `b3`=7'h12, `b4`=7'h00 (−128).
- `value`=8'hFF, `sgn`=1:
  - `b1`=7'h7E, `b2`=`b3`=7'h7F, `b4`=7'h4F.
- With `LZB`=0, `value`=42:
  - `b1`=7'h7F, `b2`=7'h01, `b3`=7'h4C, `b4`=7'h12.
- Busy and reset handling:
  - Start 42, then `start` with `value`=99 at edges k+3 and k+9: result shows 42, exactly one `done`.
  - Start 42, then start 7 at edge k+10: `done` at edge k+19 with `b4`=7'h0F.
  - Separately, drop `rst_n` at edge k+4: all outputs blank immediately and no `done` follows.

Source files
------------

// File: rtl/seg_value_encoder_if.sv
`default_nettype none
// ============================================================================
// Module  : seg_value_encoder_if
// Purpose : Request/result bundle between a value source and the
//           seg_value_encoder.
// Signals : i_start  - request conversion of i_value (master -> encoder)
//           i_sgn    - 1 = i_value is two's complement
//           i_value  - 8-bit number to display
//           o_busy   - conversion in progress     (encoder -> master)
//           o_done   - one-cycle pulse, o_b1..o_b4 updated this cycle
//           o_b1     - sign position pattern {a,b,c,d,e,f,g}
//           o_b2     - hundreds pattern
//           o_b3     - tens pattern
//           o_b4     - units pattern
// Revision: 1.0 - initial release
// ============================================================================
interface seg_value_encoder_if;
  logic       i_start;
  logic       i_sgn;
  logic [7:0] i_value;
  logic       o_busy;
  logic       o_done;
  logic [6:0] o_b1;
  logic [6:0] o_b2;
  logic [6:0] o_b3;
  logic [6:0] o_b4;

  modport master (
    output i_start, i_sgn, i_value,
    input  o_busy, o_done, o_b1, o_b2, o_b3, o_b4
  );

  modport slave (
    input  i_start, i_sgn, i_value,
    output o_busy, o_done, o_b1, o_b2, o_b3, o_b4
  );
endinterface
`default_nettype wire

// File: rtl/seg_value_encoder.sv
`default_nettype none
// ============================================================================
// Module  : seg_value_encoder
// Purpose : Converts an 8-bit (optionally signed) value into four registered
//           7-segment patterns using a sequential double-dabble pass
//           (8 shift cycles) followed by one encode cycle.
// Ports   : clk    - system clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - seg_value_encoder_if.slave (start/sgn/value in,
//                    busy/done/b1..b4 out)
// Params  : SEG_ACTIVE_LOW - 1 = segment lit when bit is 0
//           LZB            - 1 = blank leading zeros in hundreds/tens
// Revision: 1.0 - initial release
// ============================================================================
module seg_value_encoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit LZB            = 1'b1
) (
  input wire logic           clk,
  input wire logic           rst_n,
  seg_value_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_ENC  = 2'd2
  } state_t;

  // Glyphs are defined active-low; the polarity is applied once at the end.
  localparam logic [6:0] c_GLYPH_MINUS = 7'h7E;
  localparam logic [6:0] c_GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] c_SEG_BLANK   = SEG_ACTIVE_LOW ? c_GLYPH_BLANK : ~c_GLYPH_BLANK;

  state_t      r_state;
  state_t      w_next;
  logic        w_load;
  logic        w_shift;
  logic        w_enc;

  logic [7:0]  r_mag;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic        r_neg;
  logic        r_done;
  logic [6:0]  r_b1;
  logic [6:0]  r_b2;
  logic [6:0]  r_b3;
  logic [6:0]  r_b4;

  logic        w_neg;
  logic [7:0]  w_mag;
  logic [11:0] w_bcd_adj;
  logic [6:0]  w_b1;
  logic [6:0]  w_b2;
  logic [6:0]  w_b3;
  logic [6:0]  w_b4;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h01;
      4'd1:    g = 7'h4F;
      4'd2:    g = 7'h12;
      4'd3:    g = 7'h06;
      4'd4:    g = 7'h4C;
      4'd5:    g = 7'h24;
      4'd6:    g = 7'h20;
      4'd7:    g = 7'h0F;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h04;
      default: g = c_GLYPH_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] pol(input logic [6:0] p);
    return SEG_ACTIVE_LOW ? p : ~p;
  endfunction

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_enc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_load = 1'b1;
          w_next = S_CONV;
        end
      end
      S_CONV: begin
        w_shift = 1'b1;
        // r_cnt==7 means this edge performs the 8th and final shift.
        if (r_cnt == 3'd7) begin
          w_next = S_ENC;
        end
      end
      S_ENC: begin
        w_enc  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Input capture and double-dabble datapath
  // --------------------------------------------------------------------------
  assign w_neg = bus.i_sgn & bus.i_value[7];
  // Two's complement negate; 8'h80 maps to 128, which fits unsigned 8 bits.
  assign w_mag = w_neg ? (~bus.i_value + 8'd1) : bus.i_value;

  assign w_bcd_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag <= 8'd0;
      r_bcd <= 12'd0;
      r_cnt <= 3'd0;
      r_neg <= 1'b0;
    end else if (w_load) begin
      r_mag <= w_mag;
      r_bcd <= 12'd0;
      r_cnt <= 3'd0;
      r_neg <= w_neg;
    end else if (w_shift) begin
      r_bcd <= {w_bcd_adj[10:0], r_mag[7]};
      r_mag <= {r_mag[6:0], 1'b0};
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Segment encoding; loaded only at the ENC edge so the display never sees
  // intermediate BCD values.
  // --------------------------------------------------------------------------
  always_comb begin
    w_b4 = pol(glyph(r_bcd[3:0]));
    w_b3 = pol(glyph(r_bcd[7:4]));
    w_b2 = pol(glyph(r_bcd[11:8]));
    w_b1 = pol(r_neg ? c_GLYPH_MINUS : c_GLYPH_BLANK);
    if (LZB && (r_bcd[11:8] == 4'd0)) begin
      w_b2 = c_SEG_BLANK;
      if (r_bcd[7:4] == 4'd0) begin
        w_b3 = c_SEG_BLANK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_b1   <= c_SEG_BLANK;
      r_b2   <= c_SEG_BLANK;
      r_b3   <= c_SEG_BLANK;
      r_b4   <= c_SEG_BLANK;
    end else begin
      r_done <= w_enc;
      if (w_enc) begin
        r_b1 <= w_b1;
        r_b2 <= w_b2;
        r_b3 <= w_b3;
        r_b4 <= w_b4;
      end
    end
  end

  assign bus.o_busy = (r_state != S_IDLE);
  assign bus.o_done = r_done;
  assign bus.o_b1   = r_b1;
  assign bus.o_b2   = r_b2;
  assign bus.o_b3   = r_b3;
  assign bus.o_b4   = r_b4;

endmodule
`default_nettype wire
